instruction_loader: RTL and testbench
=====================================

# instruction_loader

Boot-time writer for the processor's instruction memory. It accepts a framed byte stream from a serial receiver, assembles big-endian 32-bit instruction words, and issues one write per word into the instruction RAM at consecutive word addresses. It holds the CPU in reset while a load is in progress. It sits between the UART RX block and the write port of the instruction RAM.

## Interface
- `DEPTH_WORDS`, default 256: capacity of the instruction RAM in words, so the valid word index is Address[9:2].
- `BASE_ADDR`, default 32'h00000000: byte address written by word 0.
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  one-cycle pulse that begins a load.
- `RxData`  in  8  incoming byte.
- `RxValid`  in  1  `RxData` is valid.
- `RxReady`  out  1  loader accepts a byte this cycle.
- `MemWrite`  out  1  one-cycle instruction RAM write strobe.
- `Address`  out  32  byte address for the write.
- `WriteData`  out  32  instruction word to write.
- `CpuHold`  out  1  holds the CPU in reset.
- `Done`  out  1  last load completed with a good checksum.
- `Error`  out  1  last load was rejected.

## Operation
- Frame format, in this order:
  - LEN_HI, LEN_LO: 16-bit word count N.
  - N×4 data bytes; within each word the first byte is [31:24] and the fourth is [7:0].
  - One CHK byte: XOR of all data bytes only.
- States:
  - IDLE → LEN_HI on `Start`.
  - LEN_HI → LEN_LO on byte accept.
  - LEN_LO → DATA on accept if 1 ≤ N ≤ DEPTH_WORDS; else → ERROR.
  - DATA → CHECK on accept of byte 4N.
  - CHECK → DONE if the received byte equals the running XOR; else → ERROR.
  - DONE and ERROR → LEN_HI on `Start`.
- `Start` in LEN_HI, LEN_LO, DATA or CHECK is ignored.
- Byte accept: `RxValid && RxReady`.
- `RxReady` = 1 in LEN_HI, LEN_LO, DATA and CHECK; 0 in IDLE, DONE and ERROR.
- A 2-bit byte counter and a 32-bit shift register assemble each word: `{shift[23:0], RxData}`.
- On the 4th byte of word i, register the write:
  - `MemWrite` = 1 for exactly one cycle.
  - `Address` = BASE_ADDR + 4·i, computed modulo 2^32.
  - `WriteData` = the assembled word.
- Word index i is 9 bits, reset to 0 on entry to LEN_HI.
- The running XOR is reset to 0 on entry to LEN_HI.
- `CpuHold`: set on entering LEN_HI; stays 1 through ERROR; cleared on entering DONE.
- `Done`: 1 only in DONE.
- `Error`: 1 only in ERROR.
- In ERROR, no further writes occur. Words already written are not rolled back; `CpuHold` protects the CPU from the partial image.
- `reset` asserted, including mid-load: immediately IDLE, counters cleared, all outputs 0. The partial image is abandoned.

## Timing
- Reset values: `RxReady`=0, `MemWrite`=0, `Address`=0, `WriteData`=0, `CpuHold`=0, `Done`=0, `Error`=0.
- `Start` at edge k moves the state to LEN_HI; `RxReady`=1 from cycle k+1.
- Write latency: `MemWrite` is high in the cycle after the edge that accepts the 4th byte.
  - `Address` and `WriteData` are stable during that cycle and hold until the next write.
  - The last word's write occurs in the first CHECK cycle.
- The loader never stalls the stream: one byte per cycle is sustainable, and gaps in `RxValid` are tolerated with no timeout.
- `Done` or `Error` rises the cycle after the CHK or LEN_LO byte is accepted.
- `CpuHold` falls in the same cycle that `Done` rises.

## Structure
- Shared package `loader_pkg`:
  - state enum (IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR);
  - `LEN_W`=16, `WORD_BYTES`=4, `IDX_W`=9.
- Sub-module `word_assembler`: byte counter, shift register and word-complete pulse.
- The top level holds the FSM, length register, word index, XOR accumulator and output registers.

## Test plan
- Good two-word load:
  - Stimulus: `Start`; bytes 00 02 8c 08 00 00 8c 09 00 04 05.
  - Response: writes 8c080000 to 0x0 and 8c090004 to 0x4; `Done`=1; `CpuHold`=0.
- Same frame with CHK=06 → both writes occur, then `Error`=1 and `CpuHold`=1.
- Length 00 00, and separately length 01 01 (257) → `Error` after LEN_LO; `MemWrite` never asserts.
- Good load with random `RxValid` gaps of 0–5 cycles:
  - Writes at 0x0 and 0x4 with identical data.
  - Each `MemWrite` is exactly one cycle wide.
- `reset` pulsed after 6 bytes:
  - All outputs 0 and state IDLE.
  - A fresh `Start` followed by the good frame completes normally.
- `Start` pulsed mid-DATA → ignored; the frame completes with `Done`=1 and the correct addresses.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and sizing constants for the instruction loader.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

   localparam int LEN_W      = 16;  // frame length field width (words)
   localparam int WORD_BYTES = 4;   // bytes per instruction word
   localparam int IDX_W      = 9;   // word index width, covers 0..256
   localparam int BYTE_W     = 8;
   localparam int WORD_W     = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_HI = 3'd1,
      LEN_LO = 3'd2,
      DATA   = 3'd3,
      CHECK  = 3'd4,
      DONE   = 3'd5,
      ERROR  = 3'd6
   } state_t;

endpackage
`default_nettype wire

// File: rtl/instruction_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_loader_if
// Description : Byte-stream input and instruction-RAM write port of the loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_loader_if;
   import loader_pkg::*;

   logic [BYTE_W-1:0] RxData;
   logic              RxValid;
   logic              RxReady;
   logic              MemWrite;
   logic [WORD_W-1:0] Address;
   logic [WORD_W-1:0] WriteData;

   // Loader side: consumes the byte stream, drives the RAM write port
   modport master (
      input  RxData,
      input  RxValid,
      output RxReady,
      output MemWrite,
      output Address,
      output WriteData
   );

   // Environment side: UART receiver feeding bytes, RAM observing writes
   modport slave (
      output RxData,
      output RxValid,
      input  RxReady,
      input  MemWrite,
      input  Address,
      input  WriteData
   );

endinterface
`default_nettype wire

// File: rtl/instruction_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : word_assembler
// Description : Collects bytes big-endian into 32-bit words and flags the
//               byte that completes each word.
// Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
   import loader_pkg::*;
(
   input  wire logic              clk,
   input  wire logic              reset,
   input  wire logic              clear,
   input  wire logic              byte_en,
   input  wire logic [BYTE_W-1:0] rx_data,
   output logic      [WORD_W-1:0] word,
   output logic                   word_done
);

   localparam int                CNT_W    = $clog2(WORD_BYTES);
   localparam logic [CNT_W-1:0]  c_LAST   = CNT_W'(WORD_BYTES - 1);

   // Only the three earlier bytes are stored: the completing byte is appended
   // combinationally so the word is available in the cycle it arrives.
   logic [WORD_W-BYTE_W-1:0] r_shift;
   logic [CNT_W-1:0]         r_count;

   // Byte counter and shift register advance on every accepted data byte
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift <= '0;
         r_count <= '0;
      end else if (clear) begin
         r_shift <= '0;
         r_count <= '0;
      end else if (byte_en) begin
         r_shift <= {r_shift[WORD_W-2*BYTE_W-1:0], rx_data};
         r_count <= r_count + 1'b1;
      end
   end

   assign word      = {r_shift, rx_data};
   assign word_done = byte_en && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : instruction_loader
// Description : Boot loader that writes a framed, checksummed byte stream into
//               the instruction RAM while holding the CPU in reset.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_loader
   import loader_pkg::*;
#(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             Start,
   instruction_loader_if.master  bus,
   output logic                  CpuHold,
   output logic                  Done,
   output logic                  Error
);

   localparam logic [LEN_W:0] c_DEPTH = (LEN_W+1)'(DEPTH_WORDS);

   state_t              r_state;
   logic [LEN_W-1:0]    r_len;
   logic [IDX_W-1:0]    r_word_idx;
   logic [BYTE_W-1:0]   r_xor;
   logic                r_rx_ready;
   logic                r_mem_write;
   logic [WORD_W-1:0]   r_address;
   logic [WORD_W-1:0]   r_write_data;
   logic                r_cpu_hold;
   logic                r_done;
   logic                r_error;

   logic                w_accept;
   logic                w_restart;
   logic                w_data_byte;
   logic [LEN_W-1:0]    w_len;
   logic                w_len_ok;
   logic                w_last_word;
   logic [WORD_W-1:0]   w_word;
   logic                w_word_done;

   assign w_accept    = bus.RxValid && r_rx_ready;
   assign w_restart   = Start && (r_state == IDLE || r_state == DONE || r_state == ERROR);
   assign w_data_byte = w_accept && (r_state == DATA);
   assign w_len       = {r_len[LEN_W-1:BYTE_W], bus.RxData};
   assign w_len_ok    = (w_len != '0) && ({1'b0, w_len} <= c_DEPTH);
   assign w_last_word = (LEN_W'(r_word_idx) == r_len - 1'b1);

   word_assembler u_word_assembler (
      .clk       (clk),
      .reset     (reset),
      .clear     (w_restart),
      .byte_en   (w_data_byte),
      .rx_data   (bus.RxData),
      .word      (w_word),
      .word_done (w_word_done)
   );

   // Frame FSM with registered handshake, write-port and status outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_len        <= '0;
         r_word_idx   <= '0;
         r_xor        <= '0;
         r_rx_ready   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_address    <= '0;
         r_write_data <= '0;
         r_cpu_hold   <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_mem_write <= 1'b0;
         case (r_state)
            IDLE, DONE, ERROR: begin
               if (Start) begin
                  r_state    <= LEN_HI;
                  r_word_idx <= '0;
                  r_xor      <= '0;
                  r_rx_ready <= 1'b1;
                  r_cpu_hold <= 1'b1;
                  r_done     <= 1'b0;
                  r_error    <= 1'b0;
               end
            end
            LEN_HI: begin
               if (w_accept) begin
                  r_len[LEN_W-1:BYTE_W] <= bus.RxData;
                  r_state               <= LEN_LO;
               end
            end
            LEN_LO: begin
               if (w_accept) begin
                  r_len[BYTE_W-1:0] <= bus.RxData;
                  if (w_len_ok) begin
                     r_state <= DATA;
                  end else begin
                     r_state    <= ERROR;
                     r_rx_ready <= 1'b0;
                     r_error    <= 1'b1;
                  end
               end
            end
            DATA: begin
               if (w_accept) begin
                  r_xor <= r_xor ^ bus.RxData;
                  if (w_word_done) begin
                     r_mem_write  <= 1'b1;
                     r_address    <= BASE_ADDR + WORD_W'({r_word_idx, 2'b00});
                     r_write_data <= w_word;
                     r_word_idx   <= r_word_idx + 1'b1;
                     if (w_last_word) begin
                        r_state <= CHECK;
                     end
                  end
               end
            end
            CHECK: begin
               if (w_accept) begin
                  r_rx_ready <= 1'b0;
                  if (bus.RxData == r_xor) begin
                     r_state    <= DONE;
                     r_done     <= 1'b1;
                     r_cpu_hold <= 1'b0;
                  end else begin
                     r_state <= ERROR;
                     r_error <= 1'b1;
                  end
               end
            end
            default: begin
               r_state    <= IDLE;
               r_rx_ready <= 1'b0;
            end
         endcase
      end
   end

   assign bus.RxReady   = r_rx_ready;
   assign bus.MemWrite  = r_mem_write;
   assign bus.Address   = r_address;
   assign bus.WriteData = r_write_data;
   assign CpuHold       = r_cpu_hold;
   assign Done          = r_done;
   assign Error         = r_error;

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_loader
// Description : Scoreboard bench for instruction_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_loader;

   logic clk;
   logic reset;
   logic Start;
   logic CpuHold;
   logic Done;
   logic Error;

   int total = 0;
   int bad   = 0;

   // expected writes: {address, data}
   logic [63:0] exp_q[$];

   logic [7:0] good_frame [11] = '{8'h00, 8'h02, 8'h8c, 8'h08, 8'h00, 8'h00,
                                   8'h8c, 8'h09, 8'h00, 8'h04, 8'h05};
   int         gap_tbl    [11] = '{0, 3, 5, 1, 0, 2, 4, 5, 1, 0, 3};

   instruction_loader_if bus ();

   instruction_loader #(
      .DEPTH_WORDS (256),
      .BASE_ADDR   (32'h0000_0000)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .Start   (Start),
      .bus     (bus.master),
      .CpuHold (CpuHold),
      .Done    (Done),
      .Error   (Error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: every write strobe must match the head of the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (bus.MemWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: got addr %h data %h expected no write",
                        bus.Address, bus.WriteData);
            end else begin
               logic [63:0] e;
               e = exp_q.pop_front();
               check("wr_addr", bus.Address, e[63:32]);
               check("wr_data", bus.WriteData, e[31:0]);
            end
         end
      end
   end

   task automatic pulse_start();
      Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) begin
         @(posedge clk); #1;
      end
      bus.RxData  = b;
      bus.RxValid = 1'b1;
      check("rx_ready", {31'd0, bus.RxReady}, 32'd1);
      @(posedge clk); #1;
      bus.RxValid = 1'b0;
   endtask

   task automatic push_good_writes();
      exp_q.push_back({32'h0000_0000, 32'h8c08_0000});
      exp_q.push_back({32'h0000_0004, 32'h8c09_0004});
   endtask

   task automatic send_good(input logic [7:0] chk);
      for (int i = 0; i < 10; i++) send_byte(good_frame[i], 0);
      send_byte(chk, 0);
   endtask

   task automatic check_status(input string tag, input logic d, input logic e, input logic h);
      check({tag, "_done"},  {31'd0, Done},    {31'd0, d});
      check({tag, "_error"}, {31'd0, Error},   {31'd0, e});
      check({tag, "_hold"},  {31'd0, CpuHold}, {31'd0, h});
   endtask

   task automatic settle(input string tag);
      repeat (2) begin
         @(posedge clk); #1;
      end
      check({tag, "_pending"}, exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      reset       = 1'b0;
      Start       = 1'b0;
      bus.RxData  = 8'h00;
      bus.RxValid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, bus.RxReady}, 32'd0);
      check("rst_memwr", {31'd0, bus.MemWrite}, 32'd0);
      check("rst_addr",  bus.Address, 32'd0);
      check("rst_wdata", bus.WriteData, 32'd0);
      check_status("rst", 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;

      // good two-word load
      pulse_start();
      check("start_hold", {31'd0, CpuHold}, 32'd1);
      push_good_writes();
      send_good(8'h05);
      check_status("good", 1'b1, 1'b0, 1'b0);
      check("good_ready", {31'd0, bus.RxReady}, 32'd0);
      settle("good");

      // bad checksum: writes still happen, then error
      pulse_start();
      check("restart_done", {31'd0, Done}, 32'd0);
      push_good_writes();
      send_good(8'h06);
      check_status("badchk", 1'b0, 1'b1, 1'b1);
      settle("badchk");

      // zero length
      pulse_start();
      check("restart_error", {31'd0, Error}, 32'd0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      check_status("len0", 1'b0, 1'b1, 1'b1);
      check("len0_ready", {31'd0, bus.RxReady}, 32'd0);
      settle("len0");

      // length 257 exceeds depth
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      check_status("len257", 1'b0, 1'b1, 1'b1);
      settle("len257");

      // good load with RxValid gaps
      pulse_start();
      push_good_writes();
      for (int i = 0; i < 11; i++) send_byte(good_frame[i], gap_tbl[i]);
      check_status("gaps", 1'b1, 1'b0, 1'b0);
      settle("gaps");

      // reset mid-load after 6 bytes (first word already written)
      pulse_start();
      exp_q.push_back({32'h0000_0000, 32'h8c08_0000});
      for (int i = 0; i < 6; i++) send_byte(good_frame[i], 0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("midrst_ready", {31'd0, bus.RxReady}, 32'd0);
      check("midrst_memwr", {31'd0, bus.MemWrite}, 32'd0);
      check("midrst_addr",  bus.Address, 32'd0);
      check("midrst_wdata", bus.WriteData, 32'd0);
      check_status("midrst", 1'b0, 1'b0, 1'b0);
      check("midrst_pending", exp_q.size(), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("postrst_ready", {31'd0, bus.RxReady}, 32'd0);
      pulse_start();
      push_good_writes();
      send_good(8'h05);
      check_status("afterrst", 1'b1, 1'b0, 1'b0);
      settle("afterrst");

      // Start pulsed during DATA is ignored
      pulse_start();
      push_good_writes();
      for (int i = 0; i < 5; i++) send_byte(good_frame[i], 0);
      pulse_start();
      check("midstart_ready", {31'd0, bus.RxReady}, 32'd1);
      for (int i = 5; i < 11; i++) send_byte(good_frame[i], 0);
      check_status("midstart", 1'b1, 1'b0, 1'b0);
      settle("midstart");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // absolute time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
